// File: rtl/rr_slave_port_sched.sv
// Round-robin scheduler sharing one slave port between two masters.
// One transaction in flight: request, ack and (reads only) data phase, with an optional watchdog.
module rr_slave_port_sched #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_cmd,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_cmd,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_ack,
    output logic          m0_resp,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    output logic          m1_ack,
    output logic          m1_resp,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic          s_req,
    output logic          s_cmd,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic          s_ack,
    input  logic          s_resp,
    input  logic [DW-1:0] s_rdata,
    output logic          busy,
    output logic          last_mas
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        W_ACK  = 2'd1,
        W_DATA = 2'd2
    } state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_mas_q, last_mas_d;
    logic            s_req_q, s_req_d;
    logic            s_cmd_q, s_cmd_d;
    logic [AW-1:0]   s_addr_q, s_addr_d;
    logic [DW-1:0]   s_wdata_q, s_wdata_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic grant_sel;
    logic start;
    logic to_hit;
    logic ack_w;
    logic resp_w;
    logic err_w;

    // On contention the master that was not served last wins.
    assign grant_sel = (m0_req && m1_req) ? ~last_mas_q : m1_req;
    assign start     = (state_q == IDLE) && (m0_req || m1_req);
    assign to_hit    = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = W_ACK;
            end
            W_ACK: begin
                if (s_ack)       state_d = s_cmd_q ? IDLE : W_DATA;
                else if (to_hit) state_d = IDLE;
            end
            W_DATA: begin
                if (s_resp || to_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A real ack/resp in the timeout cycle takes precedence over the abort.
    always_comb begin
        ack_w  = 1'b0;
        resp_w = 1'b0;
        err_w  = 1'b0;
        case (state_q)
            W_ACK: begin
                ack_w = s_ack;
                err_w = !s_ack && to_hit;
            end
            W_DATA: begin
                resp_w = s_resp;
                err_w  = !s_resp && to_hit;
            end
            default: ;
        endcase
    end

    always_comb begin
        grant_d    = grant_q;
        last_mas_d = last_mas_q;
        s_req_d    = s_req_q;
        s_cmd_d    = s_cmd_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    grant_d    = grant_sel;
                    last_mas_d = grant_sel;
                    s_req_d    = 1'b1;
                    s_cmd_d    = grant_sel ? m1_cmd   : m0_cmd;
                    s_addr_d   = grant_sel ? m1_addr  : m0_addr;
                    s_wdata_d  = grant_sel ? m1_wdata : m0_wdata;
                    cnt_d      = '0;
                end
            end
            W_ACK: begin
                if (s_ack) begin
                    s_req_d = 1'b0;
                    cnt_d   = '0;
                end else if (to_hit) begin
                    s_req_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            W_DATA: begin
                if (!s_resp) cnt_d = cnt_q + TO_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q    <= 1'b0;
            last_mas_q <= 1'b1;
            s_req_q    <= 1'b0;
            s_cmd_q    <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            cnt_q      <= '0;
        end else begin
            grant_q    <= grant_d;
            last_mas_q <= last_mas_d;
            s_req_q    <= s_req_d;
            s_cmd_q    <= s_cmd_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            cnt_q      <= cnt_d;
        end
    end

    assign m0_ack   = ack_w  && !grant_q;
    assign m1_ack   = ack_w  &&  grant_q;
    assign m0_resp  = resp_w && !grant_q;
    assign m1_resp  = resp_w &&  grant_q;
    assign m0_err   = err_w  && !grant_q;
    assign m1_err   = err_w  &&  grant_q;
    assign m0_rdata = m0_resp ? s_rdata : '0;
    assign m1_rdata = m1_resp ? s_rdata : '0;

    assign s_req    = s_req_q;
    assign s_cmd    = s_cmd_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign busy     = (state_q != IDLE);
    assign last_mas = last_mas_q;

endmodule

// File: tb/tb_rr_slave_port_sched.sv
// Directed bench for rr_slave_port_sched: stimulus pushes expected master-side pulses
// into a queue, a negedge monitor pops and compares whenever any master output fires.
module tb_rr_slave_port_sched;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          m0_req, m1_req;
    logic          m0_cmd, m1_cmd;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m0_resp, m0_err;
    logic          m1_ack, m1_resp, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          s_req, s_cmd;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_ack, s_resp;
    logic [DW-1:0] s_rdata;
    logic          busy, last_mas;

    typedef struct {
        string       name;
        logic [69:0] exp;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    rr_slave_port_sched #(
        .AW(AW), .DW(DW), .TO_W(8), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m0_resp(m0_resp), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_ack(m1_ack), .m1_resp(m1_resp), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata),
        .busy(busy), .last_mas(last_mas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit mas, input logic req, input logic cmd,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (!mas) begin
            m0_req = req; m0_cmd = cmd; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_cmd = cmd; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    function automatic logic [69:0] mkResp(input bit mas, input logic ack, input logic resp,
                                           input logic err, input logic [31:0] rdata);
        if (!mas) return {ack, resp, err, rdata, 3'b000, 32'h0};
        else      return {3'b000, 32'h0, ack, resp, err, rdata};
    endfunction

    task automatic expectPulse(input string name, input logic [69:0] exp);
        exp_t item;
        item.name = name;
        item.exp  = exp;
        expQ.push_back(item);
    endtask

    // Scoreboard monitor: any master-side pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (|{m0_ack, m0_resp, m0_err, m1_ack, m1_resp, m1_err}) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got %h expected none",
                         {m0_ack, m0_resp, m0_err, m0_rdata, m1_ack, m1_resp, m1_err, m1_rdata});
            end else begin
                exp_t item;
                item = expQ.pop_front();
                checkOutput(item.name,
                            {m0_ack, m0_resp, m0_err, m0_rdata, m1_ack, m1_resp, m1_err, m1_rdata},
                            item.exp);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        s_ack = 1'b0; s_resp = 1'b0; s_rdata = 32'h12345678;
        repeat (2) tick();
        checkOutput("reset_s_req",    70'(s_req),    70'(0));
        checkOutput("reset_busy",     70'(busy),     70'(0));
        checkOutput("reset_last_mas", 70'(last_mas), 70'(1));
        checkOutput("reset_s_addr",   70'(s_addr),   70'(0));
        rst_n = 1'b1;
        tick();

        // m0 write, slave acks on the second W_ACK cycle
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h10, 32'hA5A5);
        tick();
        checkOutput("t1_s_req",    70'(s_req),    70'(1));
        checkOutput("t1_s_addr",   70'(s_addr),   70'(32'h10));
        checkOutput("t1_s_wdata",  70'(s_wdata),  70'(32'hA5A5));
        checkOutput("t1_s_cmd",    70'(s_cmd),    70'(1));
        checkOutput("t1_last_mas", 70'(last_mas), 70'(0));
        tick();
        checkOutput("t1_s_req_c2", 70'(s_req), 70'(1));
        s_ack = 1'b1;
        expectPulse("t1_m0_ack", mkResp(1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h10, 32'hA5A5);
        tick();
        s_ack = 1'b0;
        checkOutput("t1_idle_busy",  70'(busy),  70'(0));
        checkOutput("t1_idle_s_req", 70'(s_req), 70'(0));

        // m1 read with data returned on the third W_DATA cycle
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        checkOutput("t2_s_addr",   70'(s_addr),   70'(32'h20));
        checkOutput("t2_s_cmd",    70'(s_cmd),    70'(0));
        checkOutput("t2_last_mas", 70'(last_mas), 70'(1));
        tick();
        s_ack = 1'b1;
        expectPulse("t2_m1_ack", mkResp(1'b1, 1'b1, 1'b0, 1'b0, 32'h0));
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        tick();
        s_ack = 1'b0;
        checkOutput("t2_wdata_s_req", 70'(s_req), 70'(0));
        checkOutput("t2_wdata_busy",  70'(busy),  70'(1));
        tick();
        tick();
        s_resp = 1'b1; s_rdata = 32'hDEADBEEF;
        expectPulse("t2_m1_resp", mkResp(1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF));
        tick();
        s_resp = 1'b0; s_rdata = 32'h12345678;
        checkOutput("t2_done_busy", 70'(busy), 70'(0));

        // Fairness from reset: continuous writes from both masters
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100, 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h200, 32'h2);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("t3_addr_%0d", i), 70'(s_addr), 70'((i % 2) ? 32'h200 : 32'h100));
            checkOutput($sformatf("t3_last_%0d", i), 70'(last_mas), 70'(i % 2));
            s_ack = 1'b1;
            expectPulse($sformatf("t3_ack_%0d", i), mkResp(1'(i % 2), 1'b1, 1'b0, 1'b0, 32'h0));
            tick();
            s_ack = 1'b0;
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, 32'h2);
        tick();

        // Watchdog: slave never acks m0, m1 waiting behind it
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h50, 32'h55);
        tick();
        checkOutput("t4_s_addr", 70'(s_addr), 70'(32'h40));
        tick();
        tick();
        tick();
        expectPulse("t4_m0_err", mkResp(1'b0, 1'b0, 1'b0, 1'b1, 32'h0));
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
        tick();
        checkOutput("t4_err_s_req", 70'(s_req), 70'(0));
        checkOutput("t4_err_busy",  70'(busy),  70'(0));
        tick();
        checkOutput("t4_next_addr", 70'(s_addr),   70'(32'h50));
        checkOutput("t4_next_last", 70'(last_mas), 70'(1));
        s_ack = 1'b1;
        expectPulse("t4_m1_ack", mkResp(1'b1, 1'b1, 1'b0, 1'b0, 32'h0));
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h50, 32'h55);
        tick();
        s_ack = 1'b0;

        // Ack arriving in the same cycle the watchdog would fire
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h60, 32'h66);
        tick();
        tick();
        tick();
        tick();
        s_ack = 1'b1;
        expectPulse("t5_m0_ack", mkResp(1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h60, 32'h66);
        tick();
        s_ack = 1'b0;
        checkOutput("t5_idle_busy", 70'(busy), 70'(0));

        // Reset during W_DATA aborts silently and restores m0 priority
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h70, 32'h0);
        tick();
        s_ack = 1'b1;
        expectPulse("t6_m0_ack", mkResp(1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h70, 32'h0);
        tick();
        s_ack = 1'b0;
        tick();
        checkOutput("t6_pre_busy", 70'(busy), 70'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_s_req", 70'(s_req), 70'(0));
        checkOutput("t6_rst_busy",  70'(busy),  70'(0));
        s_resp = 1'b1;
        tick();
        s_resp = 1'b0;
        rst_n  = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h80, 32'h8);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h90, 32'h9);
        tick();
        checkOutput("t6_prio_addr", 70'(s_addr),   70'(32'h80));
        checkOutput("t6_prio_last", 70'(last_mas), 70'(0));
        s_ack = 1'b1;
        expectPulse("t6_m0_ack2", mkResp(1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h80, 32'h8);
        tick();
        s_ack = 1'b0;
        tick();
        checkOutput("t6_m1_addr", 70'(s_addr), 70'(32'h90));
        s_ack = 1'b1;
        expectPulse("t6_m1_ack", mkResp(1'b1, 1'b1, 1'b0, 1'b0, 32'h0));
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h90, 32'h9);
        tick();
        s_ack = 1'b0;
        repeat (3) tick();

        checkOutput("scoreboard_drained", 70'(expQ.size()), 70'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
